cp0_tlb_ctrl: RTL

- CP0-side owner of the TLB programming interface: holds Index, Random, EntryLo0/1, Wired, BadVAddr and EntryHi.
- Assembles the 90-bit tlb_config bus consumed by mmu_top.
- Sequences TLBP, TLBWI and TLBWR as multi-cycle handshakes: pulses mmu_top's tlbp/tlbwi and captures tlbp_result back into Index.
- Sits between the WB stage (commands, mtc0/mfc0, TLB exceptions) and mmu_top.

---
 rtl/cp0_tlb_ctrl_if.sv | 39 +++
 rtl/cp0_tlb_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_tlb_ctrl_if.sv
// TLB command handshake and mmu_top programming bus seen by cp0_tlb_ctrl.
// Latency: none (wires only).
// Backpressure: cmd_valid must be held by the source until cmd_ready is seen high.
//
// master : cp0_tlb_ctrl side (drives cmd_ready, tlb_config, tlbwi, tlbp, asid).
// slave  : WB stage / mmu_top side (drives cmd_valid, cmd_op, tlbp_result).
// With CP0_TLBR_EN defined the bus also carries tlbr (to mmu_top) and tlbr_entry (from mmu_top).
interface cp0_tlb_ctrl_if;
    logic        cmd_valid;
    logic [1:0]  cmd_op;
    logic        cmd_ready;
    logic [89:0] tlb_config;
    logic        tlbwi;
    logic        tlbp;
    logic [31:0] tlbp_result;
    logic [7:0]  asid;
`ifdef CP0_TLBR_EN
    logic        tlbr;
    logic [77:0] tlbr_entry;

    modport master (
        input  cmd_valid, cmd_op, tlbp_result, tlbr_entry,
        output cmd_ready, tlb_config, tlbwi, tlbp, asid, tlbr
    );
    modport slave (
        output cmd_valid, cmd_op, tlbp_result, tlbr_entry,
        input  cmd_ready, tlb_config, tlbwi, tlbp, asid, tlbr
    );
`else
    modport master (
        input  cmd_valid, cmd_op, tlbp_result,
        output cmd_ready, tlb_config, tlbwi, tlbp, asid
    );
    modport slave (
        output cmd_valid, cmd_op, tlbp_result,
        input  cmd_ready, tlb_config, tlbwi, tlbp, asid
    );
`endif
endinterface

// File: rtl/cp0_tlb_ctrl.sv
// CP0 TLB register file (Index/Random/EntryLo0/1/Wired/BadVAddr/EntryHi) and TLBP/TLBWI/TLBWR sequencer.
// Latency: mfc0 read combinational; mtc0 visible next cycle; TLBWx 2 cycles, TLBP (and TLBR) 3 cycles.
// Backpressure: cmd_ready is high only in IDLE; commands offered while busy are ignored and must be held.
//
// Ports: clk, rst_n (async active-low); cp0_wr_* mtc0 write port; cp0_rd_addr/cp0_rd_data mfc0 read port;
//        exc_tlb/exc_vaddr committed TLB exception; bus (master modport) carries the command handshake
//        and the mmu_top bus (tlb_config, tlbwi, tlbp, tlbp_result, asid).
// Optional: define CP0_TLBR_EN to add TLBR (op 00): tlbr pulse and tlbr_entry load into EntryHi/EntryLo.
module cp0_tlb_ctrl #(
    parameter int TLB_ENTRIES = 16,
    parameter int IDX_W       = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cp0_wr_en,
    input  logic [4:0]  cp0_wr_addr,
    input  logic [31:0] cp0_wr_data,
    input  logic [4:0]  cp0_rd_addr,
    output logic [31:0] cp0_rd_data,
    input  logic        exc_tlb,
    input  logic [31:0] exc_vaddr,
    cp0_tlb_ctrl_if.master bus
);

    localparam logic [4:0] REG_INDEX    = 5'd0;
    localparam logic [4:0] REG_RANDOM   = 5'd1;
    localparam logic [4:0] REG_ENTRYLO0 = 5'd2;
    localparam logic [4:0] REG_ENTRYLO1 = 5'd3;
    localparam logic [4:0] REG_WIRED    = 5'd6;
    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_ENTRYHI  = 5'd10;

    localparam logic [1:0] OP_TLBP  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [IDX_W-1:0] RAND_TOP = IDX_W'(TLB_ENTRIES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRB,
        S_PRB_W,
        S_WR
`ifdef CP0_TLBR_EN
        ,
        S_RD,
        S_RD_W
`endif
    } state_t;

    state_t            state;
    logic              tlbp_q;
    logic              tlbwi_q;
    logic              cmd_ready_q;
    logic [IDX_W-1:0]  widx_q;

    logic              index_p;
    logic [IDX_W-1:0]  index_idx;
    logic [IDX_W-1:0]  random_q;
    logic [IDX_W-1:0]  wired_q;
    logic [25:0]       entrylo0;
    logic [25:0]       entrylo1;
    logic [31:0]       badvaddr;
    logic [18:0]       vpn2;
    logic [7:0]        asid_q;

    logic              wr_index;
    logic              wr_lo0;
    logic              wr_lo1;
    logic              wr_wired;
    logic              wr_hi;
    logic              tlbr_load;
    logic [77:0]       rd_entry;
    logic [3:0]        widx_field;

    assign wr_index = cp0_wr_en && (cp0_wr_addr == REG_INDEX);
    assign wr_lo0   = cp0_wr_en && (cp0_wr_addr == REG_ENTRYLO0);
    assign wr_lo1   = cp0_wr_en && (cp0_wr_addr == REG_ENTRYLO1);
    assign wr_wired = cp0_wr_en && (cp0_wr_addr == REG_WIRED);
    assign wr_hi    = cp0_wr_en && (cp0_wr_addr == REG_ENTRYHI);

`ifdef CP0_TLBR_EN
    logic tlbr_q;
    assign tlbr_load = (state == S_RD_W);
    assign rd_entry  = bus.tlbr_entry;
    assign bus.tlbr  = tlbr_q;
`else
    assign tlbr_load = 1'b0;
    assign rd_entry  = '0;
`endif

    // Bits of the inputs that carry no information for this block.
    logic unused_bits;
    assign unused_bits = ^{bus.tlbp_result[30:IDX_W], exc_vaddr[12:0]};

    // Command sequencer; all handshake outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            tlbp_q      <= 1'b0;
            tlbwi_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            widx_q      <= '0;
`ifdef CP0_TLBR_EN
            tlbr_q      <= 1'b0;
`endif
        end else begin
            tlbp_q  <= 1'b0;
            tlbwi_q <= 1'b0;
`ifdef CP0_TLBR_EN
            tlbr_q  <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        case (bus.cmd_op)
                            OP_TLBP: begin
                                state       <= S_PRB;
                                tlbp_q      <= 1'b1;
                                cmd_ready_q <= 1'b0;
                            end
                            OP_TLBWI: begin
                                state       <= S_WR;
                                tlbwi_q     <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                widx_q      <= index_idx;
                            end
                            OP_TLBWR: begin
                                // Random is frozen into widx so the write lands where it pointed at issue.
                                state       <= S_WR;
                                tlbwi_q     <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                widx_q      <= random_q;
                            end
                            default: begin
`ifdef CP0_TLBR_EN
                                state       <= S_RD;
                                tlbr_q      <= 1'b1;
                                cmd_ready_q <= 1'b0;
                                widx_q      <= index_idx;
`endif
                            end
                        endcase
                    end
                end
                S_PRB: state <= S_PRB_W;
                S_PRB_W: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
                S_WR: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
`ifdef CP0_TLBR_EN
                S_RD: state <= S_RD_W;
                S_RD_W: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
`endif
                default: begin
                    state       <= S_IDLE;
                    cmd_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // CP0 register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            index_p   <= 1'b0;
            index_idx <= '0;
            random_q  <= RAND_TOP;
            wired_q   <= '0;
            entrylo0  <= '0;
            entrylo1  <= '0;
            badvaddr  <= '0;
            vpn2      <= '0;
            asid_q    <= '0;
        end else begin
            // Probe result wins over a concurrent mtc0; P is only ever set by the probe.
            if (state == S_PRB_W) begin
                index_p   <= bus.tlbp_result[31];
                index_idx <= bus.tlbp_result[IDX_W-1:0];
            end else if (wr_index) begin
                index_idx <= cp0_wr_data[IDX_W-1:0];
            end

            if (wr_wired || random_q == wired_q || random_q == '0) begin
                random_q <= RAND_TOP;
            end else begin
                random_q <= random_q - IDX_W'(1);
            end

            if (wr_wired) begin
                wired_q <= cp0_wr_data[IDX_W-1:0];
            end

            if (exc_tlb) begin
                badvaddr <= exc_vaddr;
            end

            // A committed TLB exception overrides any mtc0 to EntryHi and keeps ASID.
            if (exc_tlb) begin
                vpn2 <= exc_vaddr[31:13];
            end else if (tlbr_load) begin
                vpn2   <= rd_entry[77:59];
                asid_q <= rd_entry[58:51];
            end else if (wr_hi) begin
                vpn2   <= cp0_wr_data[31:13];
                asid_q <= cp0_wr_data[7:0];
            end

            // The TLB keeps one global bit per pair, so it is copied into both G fields on read-back.
            if (tlbr_load) begin
                entrylo0 <= {rd_entry[49:25], rd_entry[50]};
                entrylo1 <= {rd_entry[24:0], rd_entry[50]};
            end else begin
                if (wr_lo0) entrylo0 <= cp0_wr_data[25:0];
                if (wr_lo1) entrylo1 <= cp0_wr_data[25:0];
            end
        end
    end

    always_comb begin
        cp0_rd_data = '0;
        case (cp0_rd_addr)
            REG_INDEX: begin
                cp0_rd_data[31]          = index_p;
                cp0_rd_data[IDX_W-1:0]   = index_idx;
            end
            REG_RANDOM:   cp0_rd_data[IDX_W-1:0] = random_q;
            REG_ENTRYLO0: cp0_rd_data[25:0]      = entrylo0;
            REG_ENTRYLO1: cp0_rd_data[25:0]      = entrylo1;
            REG_WIRED:    cp0_rd_data[IDX_W-1:0] = wired_q;
            REG_BADVADDR: cp0_rd_data            = badvaddr;
            REG_ENTRYHI: begin
                cp0_rd_data[31:13] = vpn2;
                cp0_rd_data[7:0]   = asid_q;
            end
            default: cp0_rd_data = '0;
        endcase
    end

    // Write index follows Index while idle so mmu_top always sees a coherent bus.
    always_comb begin
        widx_field = '0;
        widx_field[IDX_W-1:0] = (state == S_IDLE) ? index_idx : widx_q;
    end

    assign bus.tlb_config = {widx_field, 8'h00, vpn2, asid_q,
                             entrylo0[0] & entrylo1[0],
                             entrylo0[25:1], entrylo1[25:1]};
    assign bus.tlbp       = tlbp_q;
    assign bus.tlbwi      = tlbwi_q;
    assign bus.cmd_ready  = cmd_ready_q;
    assign bus.asid       = asid_q;

endmodule
